mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} arb_owner_t;

  localparam int unsigned STREAK_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store ports onto one single-port memory, one transaction in flight.
// Optional performance counters are compiled in with `define ARB_PERF_CNT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       if_stall_cnt,
  output logic [31:0]       d_grant_cnt
`endif
);

  localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_D_STREAK);

  arb_state_t          state, state_nxt;
  arb_owner_t          owner, owner_nxt;
  logic [STREAK_W-1:0] streak, streak_nxt;
  logic                sel_if;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ARB_IDLE;
      owner  <= OWN_NONE;
      streak <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      streak <= streak_nxt;
    end
  end

  // Data has priority; fetch wins when data is absent or the streak limit is hit.
  assign sel_if = if_req && (!d_req || (streak == MAX_S));

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    streak_nxt = streak;
    if_gnt     = 1'b0;
    if_rvalid  = 1'b0;
    if_rdata   = '0;
    d_gnt      = 1'b0;
    d_rvalid   = 1'b0;
    d_rdata    = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    // Outputs are held at zero for the whole reset pulse, not just until the next edge.
    if (!reset) begin
      case (state)
        ARB_IDLE: begin
          mem_req = if_req | d_req;
          if (mem_req) begin
            if (sel_if) begin
              mem_addr = if_addr;
            end else begin
              mem_we    = d_we;
              mem_addr  = d_addr;
              mem_wdata = d_wdata;
            end
            if (mem_ready) begin
              state_nxt = ARB_WAIT;
              if (sel_if) begin
                if_gnt     = 1'b1;
                owner_nxt  = OWN_IF;
                streak_nxt = '0;
              end else begin
                d_gnt     = 1'b1;
                owner_nxt = OWN_D;
                if (!if_req)
                  streak_nxt = '0;
                else if (streak != MAX_S)
                  streak_nxt = streak + STREAK_W'(1);
              end
            end
          end
        end
        ARB_WAIT: begin
          if (mem_rvalid) begin
            state_nxt = ARB_IDLE;
            owner_nxt = OWN_NONE;
            case (owner)
              OWN_IF: begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
              end
              OWN_D: begin
                d_rvalid = 1'b1;
                d_rdata  = mem_rdata;
              end
              default: ;
            endcase
          end
        end
        default: state_nxt = ARB_IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_stall_cnt <= '0;
      d_grant_cnt  <= '0;
    end else begin
      if (if_req && !if_gnt)
        if_stall_cnt <= if_stall_cnt + 32'd1;
      if (d_gnt)
        d_grant_cnt <= d_grant_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a cycle model and response scoreboard.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned MAXS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b1;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, mem_rvalid;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] if_stall_cnt, d_grant_cnt;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
    , .if_stall_cnt(if_stall_cnt), .d_grant_cnt(d_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // One-cycle memory: answers every accepted request with address + 3.
  logic        mem_auto = 1'b1, man_rv = 1'b0, rv_auto = 1'b0;
  logic [31:0] rd_auto = '0;
  always @(posedge clk) begin
    rv_auto <= mem_auto && mem_req && mem_ready;
    rd_auto <= mem_addr + 32'd3;
  end
  assign mem_rvalid = rv_auto | man_rv;
  assign mem_rdata  = man_rv ? 32'hDEAD_BEEF : rd_auto;

  typedef struct {
    arb_owner_t  side;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0, n_fail = 0;
  bit          m_wait = 0;
  int unsigned m_streak = 0, m_stall = 0, m_dgnt = 0;
  int          glog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample at negedge against the model, then advance to just after the next posedge.
  task automatic cycle();
    bit   w0, eg_if, eg_d, sel_if;
    exp_t e;
    @(negedge clk);
    if (reset) begin
      chk("rst_ctl", {26'd0, if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we}, 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      m_wait = 0; m_streak = 0; m_stall = 0; m_dgnt = 0;
      q.delete();
    end else begin
      w0 = m_wait;
      if (w0 && mem_rvalid && q.size() > 0) begin
        e = q.pop_front();
        chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, e.side == OWN_IF});
        chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, e.side == OWN_D});
        chk("owner_rdata", (e.side == OWN_IF) ? if_rdata : d_rdata, e.data);
        chk("other_rdata", (e.side == OWN_IF) ? d_rdata : if_rdata, 32'd0);
        m_wait = 0;
      end else begin
        chk("no_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
      end
      sel_if = if_req && (!d_req || m_streak == MAXS);
      eg_if  = !w0 && (if_req || d_req) && mem_ready && sel_if;
      eg_d   = !w0 && (if_req || d_req) && mem_ready && !sel_if;
      chk("mem_req", {31'd0, mem_req}, {31'd0, !w0 && (if_req || d_req)});
      chk("if_gnt", {31'd0, if_gnt}, {31'd0, eg_if});
      chk("d_gnt", {31'd0, d_gnt}, {31'd0, eg_d});
      if (eg_if || eg_d) begin
        chk("mem_addr", mem_addr, eg_if ? if_addr : d_addr);
        chk("mem_we", {31'd0, mem_we}, {31'd0, eg_d && d_we});
        chk("mem_wdata", mem_wdata, eg_d ? d_wdata : 32'd0);
        e.side = eg_if ? OWN_IF : OWN_D;
        e.data = (eg_if ? if_addr : d_addr) + 32'd3;
        q.push_back(e);
        m_wait = 1;
        if (eg_if || !if_req) m_streak = 0;
        else if (m_streak < MAXS) m_streak++;
      end
      if (if_req && !eg_if) m_stall++;
      if (eg_d) m_dgnt++;
      if (d_gnt) glog.push_back(1);
      else if (if_gnt) glog.push_back(2);
    end
    @(posedge clk); #1;
  endtask

  int exp_ord[10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

  initial begin
    // Reset with active-looking inputs: everything must read zero.
    if_req = 1; d_req = 1; d_we = 1; d_wdata = 32'h1234_5678; if_addr = 32'h44;
    cycle(); cycle();
    reset = 0; if_req = 0; d_req = 0; d_we = 0; d_wdata = '0;
    cycle();

    // Lone fetch.
    if_req = 1; if_addr = 32'h0000_0010;
    cycle();
    if_req = 0;
    cycle(); cycle();

    // Store.
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hCAFE_F00D;
    cycle();
    d_req = 0; d_we = 0;
    cycle(); cycle(); cycle();

    // Backpressure: five refused cycles, then acceptance.
    mem_ready = 0; d_req = 1; d_addr = 32'h180;
    for (int i = 0; i < 5; i++) cycle();
    mem_ready = 1;
    cycle();
    d_req = 0;
    cycle(); cycle();

    // Contention for 30 cycles.
    glog.delete();
    if_req = 1; d_req = 1; if_addr = 32'h40; d_addr = 32'h300;
    for (int i = 0; i < 30; i++) cycle();
    for (int i = 0; i < 10; i++) chk($sformatf("order_%0d", i), glog[i], exp_ord[i]);
`ifdef ARB_PERF_CNT_EN
    chk("d_grant_cnt", d_grant_cnt, m_dgnt);
    chk("if_stall_cnt", if_stall_cnt, m_stall);
`endif
    if_req = 0; d_req = 0;
    cycle(); cycle();

    // Reset while waiting, then a late memory response.
    mem_auto = 0; d_req = 1; d_addr = 32'h200;
    cycle();
    reset = 1; if_req = 1; d_we = 1; d_wdata = 32'h5555_AAAA; man_rv = 1;
    cycle();
    reset = 0; if_req = 0; d_req = 0; d_we = 0; man_rv = 0;
    cycle();
    man_rv = 1;
    cycle();
    chk("late_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    man_rv = 0; mem_auto = 1; d_req = 1; d_addr = 32'h204;
    cycle();
    d_req = 0;
    cycle(); cycle();

    chk("sb_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
